// File: rtl/chan_fifo.sv
// Multi-channel FIFO merging CHANNELS independent circular queues into one round-robin output.
// Optional pop counter port out_count is enabled by defining CHAN_FIFO_STATS_EN.
module chan_fifo #(
   parameter type T        = logic [7:0],
   parameter int  DEPTH    = 4,
   parameter int  CHANNELS = 2,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] in_valid,
   output logic [CHANNELS-1:0] in_ready,
   input  T                    in_data [CHANNELS],
   output logic                out_valid,
   input  logic                out_ready,
   output T                    out_data,
`ifdef CHAN_FIFO_STATS_EN
   output logic [31:0]         out_count,
`endif
   output logic [CW-1:0]       out_chan
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;

   T              mem_q    [CHANNELS][DEPTH];
   logic [AW-1:0] rd_ptr_q [CHANNELS];
   logic [AW-1:0] rd_ptr_d [CHANNELS];
   logic [AW-1:0] wr_ptr_q [CHANNELS];
   logic [AW-1:0] wr_ptr_d [CHANNELS];
   logic [NW-1:0] cnt_q    [CHANNELS];
   logic [NW-1:0] cnt_d    [CHANNELS];

   logic [CW-1:0]       rr_q, rr_d;
   logic [CW-1:0]       lock_sel_q, lock_sel_d;
   logic                lock_q, lock_d;
   logic [CW-1:0]       sel;
   logic [CW-1:0]       cand;
   logic                found;
   int                  idx;
   logic [CHANNELS-1:0] nonempty;
   logic [CHANNELS-1:0] push;
   logic [CHANNELS-1:0] pop_ch;
   logic                pop;

   // in_ready looks only at registered count, never at a same-cycle pop
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         nonempty[c] = (cnt_q[c] != '0);
         in_ready[c] = !rst && (cnt_q[c] != NW'(DEPTH));
         push[c]     = in_valid[c] && in_ready[c];
      end
   end

   assign out_valid = !rst && (|nonempty);

   always_comb begin
      sel   = rr_q;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         cand = CW'(idx);
         if (!found && nonempty[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
      // A stalled word keeps its channel until the consumer takes it
      if (lock_q) sel = lock_sel_q;
   end

   assign pop      = out_valid && out_ready;
   assign out_chan = sel;
   assign out_data = mem_q[sel][rd_ptr_q[sel]];

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         pop_ch[c]   = pop && (sel == CW'(c));
         rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop_ch[c]);
         wr_ptr_d[c] = wr_ptr_q[c] + AW'(push[c]);
         cnt_d[c]    = cnt_q[c] + NW'(push[c]) - NW'(pop_ch[c]);
      end
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      if (pop) begin
         rr_d   = (sel == CW'(CHANNELS - 1)) ? '0 : sel + CW'(1);
         lock_d = 1'b0;
      end else if (out_valid) begin
         lock_d     = 1'b1;
         lock_sel_d = sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            rd_ptr_q[c] <= '0;
            wr_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            rd_ptr_q[c] <= rd_ptr_d[c];
            wr_ptr_q[c] <= wr_ptr_d[c];
            cnt_q[c]    <= cnt_d[c];
         end
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   // Storage is not reset; cleared pointers make stale entries unreachable
   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_data[c];
      end
   end

`ifdef CHAN_FIFO_STATS_EN
   logic [31:0] pop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)      pop_cnt_q <= '0;
      else if (pop) pop_cnt_q <= pop_cnt_q + 32'd1;
   end

   assign out_count = pop_cnt_q;
`endif

endmodule

// File: tb/tb_chan_fifo.sv
// Directed table-driven bench for chan_fifo (T=logic[7:0], DEPTH=4, CHANNELS=2).
module tb_chan_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] in_valid;
   logic [1:0] in_ready;
   logic [7:0] in_data [2];
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [0:0] out_chan;
`ifdef CHAN_FIFO_STATS_EN
   logic [31:0] out_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chan_fifo #(.T(logic [7:0]), .DEPTH(4), .CHANNELS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef CHAN_FIFO_STATS_EN
      .out_count (out_count),
`endif
      .out_chan  (out_chan)
   );

   typedef struct {
      logic       rst;
      logic [1:0] iv;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       ordy;
      logic [1:0] eirdy;
      logic       eov;
      logic [7:0] edata;
      logic       ech;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [1:0] iv, logic [7:0] d0, logic [7:0] d1,
                               logic ordy, logic [1:0] eirdy, logic eov,
                               logic [7:0] edata, logic ech);
      vec_t v;
      v.rst = r;   v.iv = iv;       v.d0 = d0;   v.d1 = d1;     v.ordy = ordy;
      v.eirdy = eirdy; v.eov = eov; v.edata = edata; v.ech = ech;
      return v;
   endfunction

   task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs at mid-cycle, then advance past the edge
   task automatic apply(vec_t v, int row);
      rst        = v.rst;
      in_valid   = v.iv;
      in_data[0] = v.d0;
      in_data[1] = v.d1;
      out_ready  = v.ordy;
      #4;
      chk("in_ready", row, 32'(in_ready), 32'(v.eirdy));
      chk("out_valid", row, 32'(out_valid), 32'(v.eov));
      if (v.eov) begin
         chk("out_data", row, 32'(out_data), 32'(v.edata));
         chk("out_chan", row, 32'(out_chan), 32'(v.ech));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; in_data[0] = '0; in_data[1] = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;

      // reset, single word pass-through
      tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 8'h00, 0));
      tbl.push_back(mk(0, 2'b01, 8'h11, 8'h00, 0, 2'b11, 0, 8'h00, 0));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h11, 0));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 8'h00, 0));
      // fill ch1, overflow push ignored, drain
      tbl.push_back(mk(0, 2'b10, 8'h00, 8'hA0, 0, 2'b11, 0, 8'h00, 0));
      tbl.push_back(mk(0, 2'b10, 8'h00, 8'hA1, 0, 2'b11, 1, 8'hA0, 1));
      tbl.push_back(mk(0, 2'b10, 8'h00, 8'hA2, 0, 2'b11, 1, 8'hA0, 1));
      tbl.push_back(mk(0, 2'b10, 8'h00, 8'hA3, 0, 2'b11, 1, 8'hA0, 1));
      tbl.push_back(mk(0, 2'b10, 8'h00, 8'hA4, 0, 2'b01, 1, 8'hA0, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b01, 1, 8'hA0, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'hA1, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'hA2, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'hA3, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 8'h00, 0));
      // round-robin interleave
      tbl.push_back(mk(0, 2'b11, 8'h01, 8'h05, 0, 2'b11, 0, 8'h00, 0));
      tbl.push_back(mk(0, 2'b11, 8'h02, 8'h06, 0, 2'b11, 1, 8'h01, 0));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h01, 0));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h05, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h02, 0));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h06, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 8'h00, 0));
      // stalled selection stays locked on ch1 while ch0 fills
      tbl.push_back(mk(0, 2'b10, 8'h00, 8'h33, 0, 2'b11, 0, 8'h00, 0));
      tbl.push_back(mk(0, 2'b01, 8'h44, 8'h00, 0, 2'b11, 1, 8'h33, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b11, 1, 8'h33, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b11, 1, 8'h33, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h33, 1));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h44, 0));
      tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 8'h00, 0));

      for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

      // Reset with ch0 holding three words and a push pending: old data must never reappear
      apply(mk(0, 2'b01, 8'hC1, 8'h00, 0, 2'b11, 0, 8'h00, 0), 100);
      apply(mk(0, 2'b01, 8'hC2, 8'h00, 0, 2'b11, 1, 8'hC1, 0), 101);
      apply(mk(0, 2'b01, 8'hC3, 8'h00, 0, 2'b11, 1, 8'hC1, 0), 102);
      apply(mk(1, 2'b01, 8'hEE, 8'h00, 1, 2'b00, 0, 8'h00, 0), 103);
      apply(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 0, 8'h00, 0), 104);
      apply(mk(0, 2'b01, 8'h99, 8'h00, 1, 2'b11, 0, 8'h00, 0), 105);
      apply(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 1, 8'h99, 0), 106);
      apply(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b11, 0, 8'h00, 0), 107);
      apply(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 8'h00, 0), 108);

`ifdef CHAN_FIFO_STATS_EN
      apply(mk(1, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 8'h00, 0), 200);
      #4;
      chk("out_count_reset", 201, out_count, 32'd0);
      @(posedge clk);
      #1;
      // Ten words streamed through ch0, each popped the cycle after its push
      for (int i = 0; i < 10; i++) begin
         rst = 1'b0; in_valid = 2'b01; in_data[0] = 8'(i); out_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 2'b00;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #4;
      chk("out_count_ten", 202, out_count, 32'd10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #4;
      chk("out_count_cleared", 203, out_count, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
